// File: rtl/spi_target_bit_engine_if.sv
// Bus bundle for spi_target_bit_engine: arming/control from the loader, the SPI pins,
// and transaction results. The slave modport is the engine; master is its user.
// Optional macro SPI_TGT_OVERRUN_EN adds the overrun result bit.
interface spi_target_bit_engine_if #(
    parameter int unsigned MAX_BITS = 256
);
    logic                arm;
    logic [15:0]         bit_count;
    logic                cpol;
    logic                cpha;
    logic [MAX_BITS-1:0] tx_bits;
    logic                spi_sclk;
    logic                spi_cs_n;
    logic                spi_mosi;
    logic                spi_miso;
    logic                spi_miso_oe;
    logic [MAX_BITS-1:0] rx_bits;
    logic [15:0]         rx_count;
    logic                armed;
    logic                busy;
    logic                done;
    logic                aborted;
`ifdef SPI_TGT_OVERRUN_EN
    logic                overrun;
`endif

    modport slave (
        input  arm, bit_count, cpol, cpha, tx_bits, spi_sclk, spi_cs_n, spi_mosi,
`ifdef SPI_TGT_OVERRUN_EN
        output overrun,
`endif
        output spi_miso, spi_miso_oe, rx_bits, rx_count, armed, busy, done, aborted
    );

    modport master (
        output arm, bit_count, cpol, cpha, tx_bits, spi_sclk, spi_cs_n, spi_mosi,
`ifdef SPI_TGT_OVERRUN_EN
        input  overrun,
`endif
        input  spi_miso, spi_miso_oe, rx_bits, rx_count, armed, busy, done, aborted
    );
endinterface

// File: rtl/spi_target_bit_engine.sv
// SPI target bit engine: oversamples SCLK/CS_n/MOSI in the clk domain, shifts tx data out
// MSB-first on MISO and collects MOSI into rx_bits, pulsing done when CS_n deasserts.
// Optional macro SPI_TGT_OVERRUN_EN reports sample edges that arrive past bit_count.
module spi_target_bit_engine #(
    parameter int unsigned MAX_BITS    = 256,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spi_target_bit_engine_if.slave bus
);
    localparam int unsigned IdxW = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

    typedef enum logic [1:0] {StIdle, StArmed, StActive} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_prev, cs_prev;
    logic                   sclk_s, cs_s, mosi_s;

    state_e                 state;
    logic [MAX_BITS-1:0]    tx_l, sh_rx, rx_bits_q;
    logic [15:0]            bc_l, shifts_left, samples_left, rx_count_q;
    logic                   cpol_l, cpha_l;
    logic [IdxW-1:0]        idx;
    logic                   miso_q, miso_oe_q, done_q, aborted_q;

    logic                   lead, trail, sample_edge, shift_edge, cs_fall, cs_rise;
    logic                   do_sample;
    logic [MAX_BITS-1:0]    sh_rx_next;
    logic [15:0]            samples_left_next;

`ifdef SPI_TGT_OVERRUN_EN
    logic                   ovr_flag, overrun_q, extra_edge;
`endif

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Input synchronizers plus previous-value flops for edge detection; all equal depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '1;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b1;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    // Edge decode and the sample update, shared by the normal and CS-rise paths.
    always_comb begin
        lead              = (sclk_prev == cpol_l) && (sclk_s != cpol_l);
        trail             = (sclk_prev != cpol_l) && (sclk_s == cpol_l);
        sample_edge       = cpha_l ? trail : lead;
        shift_edge        = cpha_l ? lead : trail;
        cs_fall           = cs_prev && !cs_s;
        cs_rise           = !cs_prev && cs_s;
        do_sample         = (state == StActive) && sample_edge && (samples_left != 16'd0);
        sh_rx_next        = {sh_rx[MAX_BITS-2:0], mosi_s};
        samples_left_next = do_sample ? samples_left - 16'd1 : samples_left;
    end

`ifdef SPI_TGT_OVERRUN_EN
    assign extra_edge = (state == StActive) && sample_edge && (samples_left == 16'd0);
`endif

    // Transaction FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            tx_l         <= '0;
            sh_rx        <= '0;
            rx_bits_q    <= '0;
            bc_l         <= '0;
            shifts_left  <= '0;
            samples_left <= '0;
            rx_count_q   <= '0;
            cpol_l       <= 1'b0;
            cpha_l       <= 1'b0;
            idx          <= '0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
`ifdef SPI_TGT_OVERRUN_EN
            ovr_flag     <= 1'b0;
            overrun_q    <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
`ifdef SPI_TGT_OVERRUN_EN
            overrun_q <= 1'b0;
`endif
            unique case (state)
                StIdle: begin
                    if (bus.arm && (bus.bit_count != 16'd0) &&
                        (32'(bus.bit_count) <= MAX_BITS)) begin
                        tx_l       <= bus.tx_bits;
                        bc_l       <= bus.bit_count;
                        cpol_l     <= bus.cpol;
                        cpha_l     <= bus.cpha;
                        rx_count_q <= '0;
                        sh_rx      <= '0;
`ifdef SPI_TGT_OVERRUN_EN
                        ovr_flag   <= 1'b0;
`endif
                        state      <= StArmed;
                    end
                end
                StArmed: begin
                    // Only a real 1->0 edge starts; CS_n already low at arm must cycle.
                    if (cs_fall) begin
                        miso_oe_q    <= 1'b1;
                        miso_q       <= tx_l[IdxW'(bc_l - 16'd1)];
                        idx          <= IdxW'(bc_l - 16'd2);
                        shifts_left  <= bc_l - 16'd1;
                        samples_left <= bc_l;
                        state        <= StActive;
                    end
                end
                StActive: begin
                    if (cs_rise) begin
                        // A sample landing in the same cycle as CS rise still counts.
                        rx_bits_q    <= do_sample ? sh_rx_next : sh_rx;
                        rx_count_q   <= rx_count_q + 16'(do_sample);
                        samples_left <= samples_left_next;
                        done_q       <= 1'b1;
                        aborted_q    <= (samples_left_next != 16'd0);
                        miso_oe_q    <= 1'b0;
                        miso_q       <= 1'b0;
`ifdef SPI_TGT_OVERRUN_EN
                        overrun_q    <= ovr_flag | extra_edge;
`endif
                        state        <= StIdle;
                    end else begin
                        if (do_sample) begin
                            sh_rx        <= sh_rx_next;
                            samples_left <= samples_left_next;
                            rx_count_q   <= rx_count_q + 16'd1;
                        end
`ifdef SPI_TGT_OVERRUN_EN
                        if (extra_edge) begin
                            ovr_flag <= 1'b1;
                        end
`endif
                        if (shift_edge) begin
                            // With cpha=1 the first leading edge is skipped: bit already out.
                            if (cpha_l && (rx_count_q == 16'd0)) begin
                                miso_q <= miso_q;
                            end else if (shifts_left != 16'd0) begin
                                miso_q      <= tx_l[idx];
                                idx         <= idx - 1'b1;
                                shifts_left <= shifts_left - 16'd1;
                            end else begin
                                miso_q <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = miso_oe_q;
    assign bus.rx_bits     = rx_bits_q;
    assign bus.rx_count    = rx_count_q;
    assign bus.armed       = (state == StArmed);
    assign bus.busy        = (state != StIdle);
    assign bus.done        = done_q;
    assign bus.aborted     = aborted_q;
`ifdef SPI_TGT_OVERRUN_EN
    assign bus.overrun     = overrun_q;
`endif
endmodule

// File: tb/tb_spi_target_bit_engine.sv
// Directed bench for spi_target_bit_engine: an SPI host model drives the pins and
// each scenario task checks its own hand-computed results.
module tb_spi_target_bit_engine;
    localparam int unsigned MaxBits = 256;
    localparam int          H       = 6;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    spi_target_bit_engine_if #(.MAX_BITS(MaxBits)) bus ();

    spi_target_bit_engine #(
        .MAX_BITS    (MaxBits),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic arm_dut(input logic [15:0] bc, input logic [31:0] tx,
                           input logic pol, input logic pha);
        @(negedge clk);
        bus.bit_count = bc;
        bus.tx_bits   = '0;
        bus.tx_bits[31:0] = tx;
        bus.cpol      = pol;
        bus.cpha      = pha;
        bus.arm       = 1'b1;
        @(negedge clk);
        bus.arm     = 1'b0;
        bus.tx_bits = '0;
    endtask

    // Host side: n SCLK cycles, MOSI from mosi_w[n-1:0] MSB-first; CS_n raised at the end.
    task automatic spi_xfer(input logic pol, input logic pha, input int n,
                            input logic [31:0] mosi_w, output logic [31:0] miso_w);
        miso_w       = '0;
        bus.spi_sclk = pol;
        wait_clks(H);
        bus.spi_cs_n = 1'b0;
        if (!pha) bus.spi_mosi = mosi_w[n-1];
        wait_clks(H);
        for (int i = 0; i < n; i++) begin
            if (!pha) begin
                miso_w       = {miso_w[30:0], bus.spi_miso};
                bus.spi_sclk = ~pol;
                wait_clks(H);
                bus.spi_sclk = pol;
                if (i + 1 < n) bus.spi_mosi = mosi_w[n-2-i];
                wait_clks(H);
            end else begin
                bus.spi_sclk = ~pol;
                bus.spi_mosi = mosi_w[n-1-i];
                wait_clks(H);
                miso_w       = {miso_w[30:0], bus.spi_miso};
                bus.spi_sclk = pol;
                wait_clks(H);
            end
        end
        bus.spi_cs_n = 1'b1;
    endtask

    // Bounded watch for the end-of-transaction pulse.
    task automatic wait_done(output int pulses, output logic ab, output logic ov);
        pulses = 0;
        ab     = 1'b0;
        ov     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                pulses++;
                ab = bus.aborted;
`ifdef SPI_TGT_OVERRUN_EN
                ov = bus.overrun;
`endif
            end
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.arm       = 1'b0;
        bus.bit_count = '0;
        bus.cpol      = 1'b0;
        bus.cpha      = 1'b0;
        bus.tx_bits   = '0;
        bus.spi_sclk  = 1'b0;
        bus.spi_cs_n  = 1'b1;
        bus.spi_mosi  = 1'b0;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(2);
        checks++;
        if ({bus.spi_miso, bus.spi_miso_oe, bus.armed, bus.busy, bus.done, bus.aborted}
            !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000", {bus.spi_miso, bus.spi_miso_oe,
                     bus.armed, bus.busy, bus.done, bus.aborted});
        end
        checks++;
        if (bus.rx_count !== 16'd0 || bus.rx_bits !== '0) begin
            errors++;
            $display("FAIL reset_rx: rx_count=%0d want 0, rx_bits[31:0]=%h want 0",
                     bus.rx_count, bus.rx_bits[31:0]);
        end
    endtask

    task automatic test_mode0();
        logic [31:0] mi;
        int          p;
        logic        ab, ov;
        arm_dut(16'd8, 32'hA5, 1'b0, 1'b0);
        checks++;
        if (bus.armed !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL m0_armed: armed=%b busy=%b want 1 1", bus.armed, bus.busy);
        end
        spi_xfer(1'b0, 1'b0, 8, 32'h3C, mi);
        wait_done(p, ab, ov);
        checks++;
        if (mi[7:0] !== 8'hA5) begin
            errors++;
            $display("FAIL m0_miso: got %h want a5", mi[7:0]);
        end
        checks++;
        if (bus.rx_bits[7:0] !== 8'h3C || bus.rx_count !== 16'd8) begin
            errors++;
            $display("FAIL m0_rx: rx=%h cnt=%0d want 3c 8", bus.rx_bits[7:0], bus.rx_count);
        end
        checks++;
        if (p !== 1 || ab !== 1'b0 || ov !== 1'b0) begin
            errors++;
            $display("FAIL m0_done: pulses=%0d aborted=%b overrun=%b want 1 0 0", p, ab, ov);
        end
        checks++;
        if (bus.spi_miso_oe !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL m0_idle: oe=%b busy=%b want 0 0", bus.spi_miso_oe, bus.busy);
        end
    endtask

    task automatic test_mode3();
        logic [31:0] mi;
        int          p;
        logic        ab, ov;
        arm_dut(16'd16, 32'hBEEF, 1'b1, 1'b1);
        spi_xfer(1'b1, 1'b1, 16, 32'h1234, mi);
        wait_done(p, ab, ov);
        checks++;
        if (mi[15:0] !== 16'hBEEF) begin
            errors++;
            $display("FAIL m3_miso: got %h want beef", mi[15:0]);
        end
        checks++;
        if (bus.rx_bits[15:0] !== 16'h1234 || bus.rx_count !== 16'd16) begin
            errors++;
            $display("FAIL m3_rx: rx=%h cnt=%0d want 1234 16", bus.rx_bits[15:0], bus.rx_count);
        end
        checks++;
        if (p !== 1 || ab !== 1'b0) begin
            errors++;
            $display("FAIL m3_done: pulses=%0d aborted=%b want 1 0", p, ab);
        end
    endtask

    task automatic test_abort();
        logic [31:0] mi;
        int          p;
        logic        ab, ov;
        arm_dut(16'd8, 32'hC3, 1'b0, 1'b0);
        spi_xfer(1'b0, 1'b0, 5, 32'h16, mi);
        wait_done(p, ab, ov);
        checks++;
        if (bus.rx_count !== 16'd5 || bus.rx_bits[4:0] !== 5'b10110) begin
            errors++;
            $display("FAIL abort_rx: cnt=%0d rx=%b want 5 10110", bus.rx_count,
                     bus.rx_bits[4:0]);
        end
        checks++;
        if (p !== 1 || ab !== 1'b1) begin
            errors++;
            $display("FAIL abort_flag: pulses=%0d aborted=%b want 1 1", p, ab);
        end
        checks++;
        if (mi[4:0] !== 5'b11000) begin
            errors++;
            $display("FAIL abort_miso: got %b want 11000", mi[4:0]);
        end
    endtask

    task automatic test_overclock();
        logic [31:0] mi;
        int          p;
        logic        ab, ov;
        arm_dut(16'd4, 32'h9, 1'b0, 1'b0);
        spi_xfer(1'b0, 1'b0, 6, 32'h2D, mi);
        wait_done(p, ab, ov);
        checks++;
        if (mi[5:0] !== 6'b100100) begin
            errors++;
            $display("FAIL ovc_miso: got %b want 100100", mi[5:0]);
        end
        checks++;
        if (bus.rx_bits[3:0] !== 4'b1011 || bus.rx_count !== 16'd4) begin
            errors++;
            $display("FAIL ovc_rx: rx=%b cnt=%0d want 1011 4", bus.rx_bits[3:0], bus.rx_count);
        end
        checks++;
        if (p !== 1 || ab !== 1'b0) begin
            errors++;
            $display("FAIL ovc_done: pulses=%0d aborted=%b want 1 0", p, ab);
        end
`ifdef SPI_TGT_OVERRUN_EN
        checks++;
        if (ov !== 1'b1) begin
            errors++;
            $display("FAIL ovc_overrun: got %b want 1", ov);
        end
`endif
    endtask

    task automatic test_single_bit();
        logic [31:0] mi;
        int          p;
        logic        ab, ov;
        arm_dut(16'd1, 32'h1, 1'b0, 1'b1);
        spi_xfer(1'b0, 1'b1, 1, 32'h1, mi);
        wait_done(p, ab, ov);
        checks++;
        if (mi[0] !== 1'b1 || bus.rx_bits[1:0] !== 2'b01 || bus.rx_count !== 16'd1) begin
            errors++;
            $display("FAIL one_bit: miso=%b rx=%b cnt=%0d want 1 01 1", mi[0],
                     bus.rx_bits[1:0], bus.rx_count);
        end
        checks++;
        if (p !== 1 || ab !== 1'b0) begin
            errors++;
            $display("FAIL one_done: pulses=%0d aborted=%b want 1 0", p, ab);
        end
    endtask

    task automatic test_arm_handling();
        int   p;
        logic ab, ov;
        arm_dut(16'd0, 32'h5, 1'b0, 1'b0);
        checks++;
        if (bus.armed !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL arm_zero: armed=%b busy=%b want 0 0", bus.armed, bus.busy);
        end
        arm_dut(16'(MaxBits + 1), 32'h5, 1'b0, 1'b0);
        checks++;
        if (bus.armed !== 1'b0) begin
            errors++;
            $display("FAIL arm_too_big: armed=%b want 0", bus.armed);
        end
        bus.spi_sclk = 1'b0;
        bus.spi_cs_n = 1'b0;
        wait_clks(5);
        arm_dut(16'd8, 32'hFF, 1'b0, 1'b0);
        wait_clks(10);
        checks++;
        if (bus.armed !== 1'b1 || bus.spi_miso_oe !== 1'b0) begin
            errors++;
            $display("FAIL arm_cs_low: armed=%b oe=%b want 1 0", bus.armed, bus.spi_miso_oe);
        end
        bus.spi_cs_n = 1'b1;
        wait_clks(5);
        checks++;
        if (bus.armed !== 1'b1) begin
            errors++;
            $display("FAIL arm_cs_high: armed=%b want 1", bus.armed);
        end
        bus.spi_cs_n = 1'b0;
        wait_clks(5);
        checks++;
        if (bus.armed !== 1'b0 || bus.busy !== 1'b1 || bus.spi_miso_oe !== 1'b1 ||
            bus.spi_miso !== 1'b1) begin
            errors++;
            $display("FAIL arm_active: armed=%b busy=%b oe=%b miso=%b want 0 1 1 1",
                     bus.armed, bus.busy, bus.spi_miso_oe, bus.spi_miso);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.spi_miso_oe !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: oe=%b busy=%b want 0 0", bus.spi_miso_oe, bus.busy);
        end
        wait_clks(2);
        rst_n        = 1'b1;
        bus.spi_cs_n = 1'b1;
        wait_done(p, ab, ov);
        checks++;
        if (p !== 0) begin
            errors++;
            $display("FAIL rst_no_done: pulses=%0d want 0", p);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_mode0();
        test_mode3();
        test_abort();
        test_overclock();
        test_single_bit();
        test_arm_handling();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
